// File: rtl/fila_circular.sv
// Parametrised circular-buffer FIFO with occupancy status and sticky error flags.
// Optional synchronous flush port enabled by defining FILA_FLUSH_EN.
module fila_circular #(
    parameter  int DATA_W = 8,
    parameter  int DEPTH  = 8,
    localparam int LEN_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_10KHz,
    input  logic              reset,
`ifdef FILA_FLUSH_EN
    input  logic              flush_in,
`endif
    input  logic [DATA_W-1:0] data_in,
    input  logic              enqueue_in,
    input  logic              dequeue_in,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid_out,
    output logic [DATA_W-1:0] head_out,
    output logic [LEN_W-1:0]  len_out,
    output logic              full_out,
    output logic              empty_out,
    output logic              overflow_out,
    output logic              underflow_out
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LEN_W-1:0]  count;
    logic              flush;
    logic              enq_ok;
    logic              deq_ok;

`ifdef FILA_FLUSH_EN
    assign flush = flush_in;
`else
    assign flush = 1'b0;
`endif

    // Explicit wrap so non power-of-two depths work
    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign deq_ok = dequeue_in && (count != '0);
    // A full queue still accepts a write when a read frees a slot on the same edge
    assign enq_ok = enqueue_in && ((count != LEN_W'(DEPTH)) || deq_ok);

    assign len_out   = count;
    assign full_out  = (count == LEN_W'(DEPTH));
    assign empty_out = (count == '0);
    assign head_out  = (count != '0) ? mem[rd_ptr] : '0;

    always_ff @(posedge clk_10KHz or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            data_out       <= '0;
            data_valid_out <= 1'b0;
            overflow_out   <= 1'b0;
            underflow_out  <= 1'b0;
        end else begin
            data_valid_out <= 1'b0;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (enq_ok) begin
                    mem[wr_ptr] <= data_in;
                    wr_ptr      <= nxt(wr_ptr);
                end
                if (deq_ok) begin
                    data_out       <= mem[rd_ptr];
                    rd_ptr         <= nxt(rd_ptr);
                    data_valid_out <= 1'b1;
                end
                if (enqueue_in && !enq_ok) overflow_out  <= 1'b1;
                if (dequeue_in && !deq_ok) underflow_out <= 1'b1;
                unique case ({enq_ok, deq_ok})
                    2'b10:   count <= count + LEN_W'(1);
                    2'b01:   count <= count - LEN_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fila_circular.sv
// Scoreboard bench for fila_circular (DEPTH=8, DATA_W=8).
// Flush checks are included when FILA_FLUSH_EN is defined.
module tb_fila_circular;

    logic       clk_10KHz = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       enqueue_in;
    logic       dequeue_in;
    logic [7:0] data_out;
    logic       data_valid_out;
    logic [7:0] head_out;
    logic [3:0] len_out;
    logic       full_out;
    logic       empty_out;
    logic       overflow_out;
    logic       underflow_out;
`ifdef FILA_FLUSH_EN
    logic       flush_in = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    logic [7:0] sb [$];

    fila_circular #(.DATA_W(8), .DEPTH(8)) dut (
        .clk_10KHz      (clk_10KHz),
        .reset          (reset),
`ifdef FILA_FLUSH_EN
        .flush_in       (flush_in),
`endif
        .data_in        (data_in),
        .enqueue_in     (enqueue_in),
        .dequeue_in     (dequeue_in),
        .data_out       (data_out),
        .data_valid_out (data_valid_out),
        .head_out       (head_out),
        .len_out        (len_out),
        .full_out       (full_out),
        .empty_out      (empty_out),
        .overflow_out   (overflow_out),
        .underflow_out  (underflow_out)
    );

    always #5 clk_10KHz = ~clk_10KHz;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every data_valid_out pulse must match the next expected entry
    always @(negedge clk_10KHz) begin
        if (reset === 1'b1 && data_valid_out === 1'b1) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_valid: got data %0h expected no output", data_out);
            end else begin
                logic [7:0] e;
                e = sb.pop_front();
                if (data_out !== e) begin
                    bad++;
                    $display("FAIL deq_data: got %0h expected %0h", data_out, e);
                end
            end
        end
    end

    task automatic cyc(input logic e, input logic d, input logic [7:0] v,
                       input logic push, input logic [7:0] exp);
        enqueue_in = e;
        dequeue_in = d;
        data_in    = v;
        if (push) sb.push_back(exp);
        @(posedge clk_10KHz);
        #1;
        enqueue_in = 1'b0;
        dequeue_in = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        reset = 1'b0; data_in = '0; enqueue_in = 1'b0; dequeue_in = 1'b0;
        repeat (2) @(posedge clk_10KHz);
        #1;
        chk("rst_len", len_out, 0);
        chk("rst_empty", empty_out, 1);
        chk("rst_full", full_out, 0);
        chk("rst_head", head_out, 0);
        chk("rst_dout", data_out, 0);
        chk("rst_flags", {overflow_out, underflow_out, data_valid_out}, 0);
        #2 reset = 1'b1;
        @(posedge clk_10KHz); #1;

        // Fill with 0x11..0x88
        for (int i = 1; i <= 8; i++) begin
            v = 8'(i * 17);
            cyc(1, 0, v, 0, 0);
            chk("fill_len", len_out, i);
        end
        chk("fill_full", full_out, 1);
        chk("fill_head", head_out, 8'h11);
        chk("fill_ovf", overflow_out, 0);

        cyc(1, 0, 8'h99, 0, 0);
        chk("ovf_len", len_out, 8);
        chk("ovf_flag", overflow_out, 1);
        chk("ovf_head", head_out, 8'h11);

        for (int i = 1; i <= 8; i++) begin
            v = 8'(i * 17);
            cyc(0, 1, 0, 1, v);
            chk("drain_valid", data_valid_out, 1);
        end
        chk("drain_empty", empty_out, 1);
        chk("drain_head", head_out, 0);
        chk("drain_udf_pre", underflow_out, 0);

        cyc(0, 1, 0, 0, 0);
        chk("udf_flag", underflow_out, 1);
        chk("udf_hold", data_out, 8'h88);
        chk("udf_valid", data_valid_out, 0);

        // Wrap: enq 5, deq 5, enq 6, deq 6
        for (int i = 1; i <= 5; i++) cyc(1, 0, 8'(i), 0, 0);
        for (int i = 1; i <= 5; i++) cyc(0, 1, 0, 1, 8'(i));
        for (int i = 0; i < 6; i++) cyc(1, 0, 8'(8'hA0 + i), 0, 0);
        chk("wrap_len", len_out, 6);
        chk("wrap_head", head_out, 8'hA0);
        for (int i = 0; i < 6; i++) cyc(0, 1, 0, 1, 8'(8'hA0 + i));
        chk("wrap_empty", empty_out, 1);

        // Mid-stream reset while full
        for (int i = 0; i < 8; i++) cyc(1, 0, 8'(8'hC0 + i), 0, 0);
        chk("pre_rst_full", full_out, 1);
        #3 reset = 1'b0;
        #1;
        chk("mrst_len", len_out, 0);
        chk("mrst_empty", empty_out, 1);
        chk("mrst_full", full_out, 0);
        chk("mrst_head", head_out, 0);
        chk("mrst_dout", data_out, 0);
        chk("mrst_flags", {overflow_out, underflow_out}, 0);
        @(posedge clk_10KHz); #2 reset = 1'b1;
        @(posedge clk_10KHz); #1;

        // Full + enq + deq pass-through
        for (int i = 0; i < 8; i++) cyc(1, 0, 8'(8'hC0 + i), 0, 0);
        cyc(1, 1, 8'h5A, 1, 8'hC0);
        chk("pt_len", len_out, 8);
        chk("pt_ovf", overflow_out, 0);
        chk("pt_head", head_out, 8'hC1);
        for (int i = 1; i < 8; i++) cyc(0, 1, 0, 1, 8'(8'hC0 + i));
        cyc(0, 1, 0, 1, 8'h5A);
        chk("pt_empty", empty_out, 1);

        // Empty + enq + deq: enqueue wins, underflow set
        cyc(1, 1, 8'h3C, 0, 0);
        chk("eq_len", len_out, 1);
        chk("eq_head", head_out, 8'h3C);
        chk("eq_udf", underflow_out, 1);
        chk("eq_valid", data_valid_out, 0);
        cyc(0, 1, 0, 1, 8'h3C);

`ifdef FILA_FLUSH_EN
        for (int i = 0; i < 4; i++) cyc(1, 0, 8'(8'h60 + i), 0, 0);
        chk("fl_pre_len", len_out, 4);
        flush_in = 1'b1;
        cyc(1, 1, 8'hEE, 0, 0);
        flush_in = 1'b0;
        chk("fl_len", len_out, 0);
        chk("fl_empty", empty_out, 1);
        chk("fl_flags", {overflow_out, underflow_out}, 2'b01);
        chk("fl_dout", data_out, 8'h3C);
        chk("fl_valid", data_valid_out, 0);
        cyc(1, 0, 8'h77, 0, 0);
        cyc(0, 1, 0, 1, 8'h77);
`endif

        repeat (2) @(posedge clk_10KHz);
        #1;
        chk("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
